// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the six-opcode datapath
// (lw, sw, add, addi, sub, div). Walks each instruction through fetch, decode,
// execute, memory/divide and writeback, and parks in a sticky trap state on an
// illegal opcode or a divider that never answers.
`timescale 1ns/1ps

module multicycle_sequencer #(
  parameter int DIV_TIMEOUT = 64,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instdata,
  input  logic             imem_valid,
  input  logic             dmem_ready,
  input  logic             div_done,
  output logic             imem_req,
  output logic             ir_load,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             div_start,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             mem_to_reg,
  output logic             reg_wr,
  output logic             pc_inc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired
);

  localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_SW   = 6'd2;
  localparam logic [5:0] OP_ADD  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_SUB  = 6'd5;
  localparam logic [5:0] OP_DIV  = 6'd6;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_DIV_TO  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_DIV,
    S_WB,
    S_RETIRE,
    S_TRAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       opcode;
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       cause_q;

  logic             load_op;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cause_set;
  logic [1:0]       cause_val;
  logic             retire_now;

  logic [3:0]       op_alu;
  logic             op_imm;

  // Only the opcode field of the instruction word matters to the sequencer.
  logic             unused_fields;
  assign unused_fields = ^instdata[25:0];

  // Static per-opcode ALU selection; lw/sw use the adder for address generation.
  always_comb begin
    op_alu = ALU_IDLE;
    op_imm = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: begin
        op_alu = ALU_ADD;
        op_imm = 1'b1;
      end
      OP_ADD: op_alu = ALU_ADD;
      OP_SUB: op_alu = ALU_SUB;
      OP_DIV: op_alu = ALU_DIV;
      default: begin
        op_alu = ALU_IDLE;
        op_imm = 1'b0;
      end
    endcase
  end

  // Next-state logic plus the side effects on the opcode, divide timer and trap cause.
  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cause_set = 1'b0;
    cause_val = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        if (run && imem_valid) begin
          load_op   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_NOP) begin
          state_nxt = S_RETIRE;
        end else if (opcode <= OP_DIV) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_set = 1'b1;
          cause_val = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM;
          OP_DIV: begin
            state_nxt = S_DIV;
            cnt_clr   = 1'b1;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_nxt = (opcode == OP_LW) ? S_WB : S_RETIRE;
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_nxt = S_WB;
        end else if (div_cnt == CNT_LAST) begin
          state_nxt = S_TRAP;
          cause_set = 1'b1;
          cause_val = CAUSE_DIV_TO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_RETIRE: state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  assign retire_now = (state == S_WB) || (state == S_RETIRE);

  // State register, latched opcode, divide timer, sticky trap cause and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      opcode  <= OP_NOP;
      div_cnt <= '0;
      cause_q <= CAUSE_NONE;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (load_op) begin
        opcode <= instdata[31:26];
      end
      if (cnt_clr) begin
        div_cnt <= '0;
      end else if (cnt_inc) begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      if (cause_set) begin
        cause_q <= cause_val;
      end
      if (retire_now) begin
        retired <= retired + RET_W'(1);
      end
    end
  end

  // Control outputs decoded from state and latched opcode; only the fetch
  // handshake looks at inputs, and it is held off while reset is asserted.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    alu_op     = ALU_IDLE;
    alu_src    = 1'b0;
    div_start  = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    pc_inc     = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = run && !rst;
        ir_load  = run && imem_valid && !rst;
      end
      S_EXEC: begin
        alu_op    = op_alu;
        alu_src   = op_imm;
        div_start = (opcode == OP_DIV);
      end
      S_MEM: begin
        alu_op  = op_alu;
        alu_src = op_imm;
        dmem_rd = (opcode == OP_LW);
        dmem_wr = (opcode == OP_SW);
      end
      S_DIV: begin
        alu_op = ALU_DIV;
      end
      S_WB: begin
        alu_op     = op_alu;
        alu_src    = op_imm;
        reg_wr     = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        pc_inc     = 1'b1;
      end
      S_RETIRE: begin
        pc_inc = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

  assign trap_cause = cause_q;

  // Memory read and write are never requested together.
  assert property (@(posedge clk) disable iff (rst) !(dmem_rd && dmem_wr));

  // A trapped sequencer never writes or retires.
  assert property (@(posedge clk) disable iff (rst)
                   trap |-> !(reg_wr || dmem_wr || pc_inc || imem_req));

endmodule
